sha256_hash_loader: RTL and testbench

Upstream front-end for sha256_manager. Accepts the target digest as 64 ASCII hex characters plus a CR/LF terminator on a byte stream, normally fed by a UART receiver. It validates and packs the characters into the 256-bit hash, clears the manager, then pulses start. It applies back-pressure on the stream until the manager reports finish.

---
 rtl/sha256_pkg.sv | 35 +++
 rtl/ascii_hex_decode.sv | 35 +++
 rtl/sha256_hash_loader.sv | 184 ++++++++++++++++++
 tb/tb_sha256_hash_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_pkg
//  Purpose  : Shared types and constants for the SHA-256 hash loader front-end
//  Revision : 1.0  initial release
// ============================================================================
package sha256_pkg;

  // Loader state encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RECEIVE   = 3'd1,
    ST_WAIT_TERM = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_LAUNCH    = 3'd4,
    ST_RUNNING   = 3'd5,
    ST_FLUSH     = 3'd6
  } state_t;

  // Error codes reported on error_code
  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_BADCHAR = 3'd1;
  localparam logic [2:0] ERR_SHORT   = 3'd2;
  localparam logic [2:0] ERR_LONG    = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  // Line terminators
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // Hex characters in one SHA-256 digest
  localparam int HASH_CHARS = 64;

endpackage
`default_nettype wire

// File: rtl/ascii_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ascii_hex_decode
//  Purpose  : Classifies one ASCII byte as hex digit / line terminator and
//             returns the 4-bit value of a hex digit (either letter case)
//  Revision : 1.0  initial release
// ============================================================================
module ascii_hex_decode
  import sha256_pkg::*;
(
  input  logic [7:0] data,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_term
);

  // Range decode of the three hex digit groups plus CR/LF detection
  always_comb begin
    nibble  = 4'd0;
    is_hex  = 1'b0;
    is_term = (data == CHAR_CR) || (data == CHAR_LF);
    if (data >= 8'h30 && data <= 8'h39) begin
      is_hex = 1'b1;
      nibble = 4'(data - 8'h30);
    end else if (data >= 8'h61 && data <= 8'h66) begin
      is_hex = 1'b1;
      nibble = 4'(data - 8'h57);
    end else if (data >= 8'h41 && data <= 8'h46) begin
      is_hex = 1'b1;
      nibble = 4'(data - 8'h37);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha256_hash_loader.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_hash_loader
//  Purpose  : Receives a 64-character hex digest line on a byte stream, packs
//             it into a 256-bit hash, clears the manager and launches it,
//             holding off the stream until the manager finishes
//  Revision : 1.0  initial release
// ============================================================================
module sha256_hash_loader
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int CLEAR_CYCLES   = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [7:0]   s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  output logic [255:0] hash,
  output logic         start,
  output logic         mgr_aresetn,
  input  logic         manager_finish,
  output logic         busy,
  output logic         error,
  output logic [2:0]   error_code
);

  // Timer counts 0..TIMEOUT_CYCLES-1; CLEAR counter counts 0..CLEAR_CYCLES-1
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'((CLEAR_CYCLES > 1) ? CLEAR_CYCLES - 1 : 0);
  localparam bit               TMR_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [6:0]       CNT_LAST = 7'(HASH_CHARS - 1);

  state_t             state;
  logic [255:0]       shift_reg;
  logic [6:0]         count;
  logic [TMR_W-1:0]   timer;
  logic [CLR_W-1:0]   clr_cnt;
  logic [3:0]         nibble;
  logic               is_hex;
  logic               is_term;
  logic               accept;
  logic               timed_out;

  ascii_hex_decode u_decode (
    .data    (s_axis_tdata),
    .nibble  (nibble),
    .is_hex  (is_hex),
    .is_term (is_term)
  );

  assign accept      = s_axis_tvalid & s_axis_tready;
  assign timed_out   = TMR_EN && !accept && (timer == TMR_LAST);
  // Manager is held in reset whenever we are, and for the whole CLEAR phase
  assign mgr_aresetn = aresetn & (state != ST_CLEAR);

  // Loader FSM with registered stream handshake, launch and status outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      shift_reg     <= '0;
      count         <= '0;
      timer         <= '0;
      clr_cnt       <= '0;
      hash          <= '0;
      start         <= 1'b0;
      busy          <= 1'b0;
      error         <= 1'b0;
      error_code    <= ERR_NONE;
      s_axis_tready <= 1'b0;
    end else begin
      start <= 1'b0;
      error <= 1'b0;

      // Inter-byte timer only runs while a digest is partially received
      if (accept || !(state == ST_RECEIVE || state == ST_WAIT_TERM))
        timer <= '0;
      else
        timer <= timer + 1'b1;

      case (state)
        ST_IDLE: begin
          s_axis_tready <= 1'b1;
          if (accept) begin
            if (is_hex) begin
              shift_reg <= {252'd0, nibble};
              count     <= 7'd1;
              state     <= ST_RECEIVE;
            end else if (!is_term) begin
              error      <= 1'b1;
              error_code <= ERR_BADCHAR;
              state      <= ST_FLUSH;
            end
          end
        end

        ST_RECEIVE: begin
          s_axis_tready <= 1'b1;
          if (accept) begin
            if (is_hex) begin
              shift_reg <= {shift_reg[251:0], nibble};
              count     <= count + 7'd1;
              if (count == CNT_LAST)
                state <= ST_WAIT_TERM;
            end else if (is_term) begin
              error      <= 1'b1;
              error_code <= ERR_SHORT;
              state      <= ST_IDLE;
            end else begin
              error      <= 1'b1;
              error_code <= ERR_BADCHAR;
              state      <= ST_FLUSH;
            end
          end else if (timed_out) begin
            error      <= 1'b1;
            error_code <= ERR_TIMEOUT;
            state      <= ST_IDLE;
          end
        end

        ST_WAIT_TERM: begin
          s_axis_tready <= 1'b1;
          if (accept) begin
            if (is_term) begin
              hash          <= shift_reg;
              clr_cnt       <= '0;
              s_axis_tready <= 1'b0;
              state         <= ST_CLEAR;
            end else begin
              error      <= 1'b1;
              error_code <= is_hex ? ERR_LONG : ERR_BADCHAR;
              state      <= ST_FLUSH;
            end
          end else if (timed_out) begin
            error      <= 1'b1;
            error_code <= ERR_TIMEOUT;
            state      <= ST_IDLE;
          end
        end

        ST_CLEAR: begin
          s_axis_tready <= 1'b0;
          if (clr_cnt == CLR_LAST) begin
            start <= 1'b1;
            busy  <= 1'b1;
            state <= ST_LAUNCH;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end

        ST_LAUNCH: begin
          busy  <= 1'b1;
          state <= ST_RUNNING;
        end

        ST_RUNNING: begin
          if (manager_finish) begin
            busy          <= 1'b0;
            s_axis_tready <= 1'b1;
            state         <= ST_IDLE;
          end
        end

        ST_FLUSH: begin
          s_axis_tready <= 1'b1;
          if (accept && is_term)
            state <= ST_IDLE;
        end

        default: begin
          busy          <= 1'b0;
          s_axis_tready <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_hash_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_hash_loader
//  Purpose  : Self-checking bench for sha256_hash_loader: directed digest
//             lines, randomized lines against a line-level reference model,
//             timeout and mid-receive reset
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha256_hash_loader;

  localparam int TMO = 50;
  localparam logic [255:0] KNOWN =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [7:0]   s_axis_tdata = 8'h00;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [255:0] hash;
  logic         start;
  logic         mgr_aresetn;
  logic         manager_finish = 1'b0;
  logic         busy;
  logic         error;
  logic [2:0]   error_code;

  sha256_hash_loader #(.TIMEOUT_CYCLES(TMO), .CLEAR_CYCLES(2)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .hash           (hash),
    .start          (start),
    .mgr_aresetn    (mgr_aresetn),
    .manager_finish (manager_finish),
    .busy           (busy),
    .error          (error),
    .error_code     (error_code)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int mgr_low_cnt = 0;
  logic [2:0] exp_code = 3'd0;
  logic [7:0] line_q[$];

  // Event counters over whole cycles (values seen just before each edge)
  always @(posedge aclk) begin
    if (start) start_cnt <= start_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
    if (aresetn && !mgr_aresetn) mgr_low_cnt <= mgr_low_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_hex_b(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
  endfunction

  function automatic bit is_term_b(input logic [7:0] b);
    return b == 8'd13 || b == 8'd10;
  endfunction

  function automatic logic [3:0] hexval(input logic [7:0] b);
    int v;
    if (b <= "9") v = int'(b) - 48;
    else if (b >= "a") v = int'(b) - 97 + 10;
    else v = int'(b) - 65 + 10;
    return 4'(v);
  endfunction

  function automatic logic [7:0] rand_hex();
    int v = $urandom_range(0, 15);
    if (v < 10) return 8'(48 + v);
    if ($urandom_range(0, 1) == 1) return 8'(87 + v);
    return 8'(55 + v);
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (is_hex_b(b) || is_term_b(b));
    return b;
  endfunction

  // Reference: outcome of one line started from idle. code 0 means launch.
  // Leading terminators are skipped; then count the run of hex characters
  // and look at what ends it.
  function automatic void eval_line(output logic [2:0] code, output logic [255:0] h);
    int i = 0;
    int n = 0;
    h = '0;
    while (i < line_q.size() && is_term_b(line_q[i])) i++;
    while (i < line_q.size() && is_hex_b(line_q[i])) begin
      if (n < 64) h = h * 16 + 256'(hexval(line_q[i]));
      n++;
      i++;
    end
    if (n > 64)                        code = 3'd3;
    else if (i >= line_q.size())       code = 3'd1;
    else if (n == 64)                  code = is_term_b(line_q[i]) ? 3'd0 : 3'd1;
    else if (n > 0 && is_term_b(line_q[i])) code = 3'd2;
    else                               code = 3'd1;
  endfunction

  task automatic load_str(input string s, input logic [7:0] term);
    line_q.delete();
    for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
    line_q.push_back(term);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    repeat ($urandom_range(0, 2)) @(negedge aclk);
    @(negedge aclk);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (w = 0; w < 100 && !s_axis_tready; w++) @(negedge aclk);
    check_eq("tready_wait", 256'(w < 100), 256'd1);
    @(posedge aclk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic run_line();
    logic [2:0]   code;
    logic [255:0] h;
    logic [255:0] held;
    int s0, e0, m0;
    bit seen;
    eval_line(code, h);
    s0 = start_cnt; e0 = err_cnt; m0 = mgr_low_cnt;
    foreach (line_q[i]) send_byte(line_q[i]);
    if (code == 3'd0) begin
      seen = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(negedge aclk);
        if (start) begin seen = 1'b1; break; end
      end
      check_eq("start_seen", 256'(seen), 256'd1);
      check_eq("hash", hash, h);
      check_eq("busy_launch", 256'(busy), 256'd1);
      check_eq("tready_launch", 256'(s_axis_tready), 256'd0);
      held = hash;
      repeat (1 + $urandom_range(0, 4)) @(negedge aclk);
      check_eq("busy_running", 256'(busy), 256'd1);
      check_eq("hash_stable", hash, held);
      manager_finish = 1'b1;
      @(negedge aclk);
      manager_finish = 1'b0;
      check_eq("tready_after_finish", 256'(s_axis_tready), 256'd1);
      check_eq("busy_after_finish", 256'(busy), 256'd0);
      check_eq("start_count", 256'(start_cnt - s0), 256'd1);
      check_eq("mgr_low_cycles", 256'(mgr_low_cnt - m0), 256'd2);
      check_eq("err_count_ok", 256'(err_cnt - e0), 256'd0);
      check_eq("err_code_held", 256'(error_code), 256'(exp_code));
    end else begin
      repeat (3) @(negedge aclk);
      exp_code = code;
      check_eq("err_code", 256'(error_code), 256'(exp_code));
      check_eq("err_count", 256'(err_cnt - e0), 256'd1);
      check_eq("no_start", 256'(start_cnt - s0), 256'd0);
      check_eq("tready_idle", 256'(s_axis_tready), 256'd1);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_hash"}, hash, 256'd0);
    check_eq({tag, "_start"}, 256'(start), 256'd0);
    check_eq({tag, "_busy"}, 256'(busy), 256'd0);
    check_eq({tag, "_tready"}, 256'(s_axis_tready), 256'd0);
    check_eq({tag, "_error"}, 256'(error), 256'd0);
    check_eq({tag, "_code"}, 256'(error_code), 256'd0);
    check_eq({tag, "_mgr"}, 256'(mgr_aresetn), 256'd0);
  endtask

  initial begin
    string dg;
    string s;
    int k;
    int e0;
    dg = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";

    repeat (3) @(negedge aclk);
    check_reset_values("reset");
    aresetn = 1'b1;

    // Directed lines
    load_str(dg, 8'h0A); run_line();
    check_eq("known_hash", hash, KNOWN);
    load_str(dg.toupper(), 8'h0D); run_line();
    check_eq("upper_hash", hash, KNOWN);
    check_eq("upper_no_error", 256'(error_code), 256'd0);
    load_str("ba7816bf8f", 8'h0A); run_line();
    load_str("ba78g1234", 8'h0A); run_line();
    load_str(dg, 8'h0A); run_line();
    check_eq("code_kept_after_launch", 256'(error_code), 256'd1);
    load_str({dg, "5"}, 8'h0A); run_line();

    // Timeout: 20 characters then silence
    for (int i = 0; i < 20; i++) send_byte(rand_hex());
    e0 = err_cnt;
    for (k = 1; k <= 60; k++) begin
      @(posedge aclk);
      @(negedge aclk);
      if (error) break;
    end
    exp_code = 3'd4;
    check_eq("timeout_cycle", 256'(k), 256'(TMO));
    check_eq("timeout_code", 256'(error_code), 256'd4);
    @(negedge aclk);
    check_eq("timeout_err_count", 256'(err_cnt - e0), 256'd1);
    check_eq("timeout_idle_tready", 256'(s_axis_tready), 256'd1);

    // Randomized lines against the line-level model
    for (int n = 0; n < 14; n++) begin
      int kind = $urandom_range(0, 5);
      int len;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge aclk);
        manager_finish = 1'b1;
        @(negedge aclk);
        manager_finish = 1'b0;
      end
      line_q.delete();
      if ($urandom_range(0, 3) == 0) line_q.push_back(8'h0D);
      case (kind)
        0, 1: len = 64;
        2:    len = $urandom_range(1, 63);
        3:    len = $urandom_range(65, 68);
        default: len = $urandom_range(0, 64);
      endcase
      for (int i = 0; i < len; i++) line_q.push_back(rand_hex());
      if (kind >= 4) begin
        line_q.push_back(rand_bad());
        for (int i = 0; i < $urandom_range(0, 4); i++)
          line_q.push_back($urandom_range(0, 1) == 1 ? rand_hex() : rand_bad());
      end
      line_q.push_back($urandom_range(0, 1) == 1 ? 8'h0A : 8'h0D);
      run_line();
    end

    // Make sure a non-zero hash is present, then reset mid-receive
    load_str(dg, 8'h0A); run_line();
    for (int i = 0; i < 10; i++) send_byte(rand_hex());
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check_reset_values("midreset");
    aresetn = 1'b1;
    exp_code = 3'd0;
    line_q.delete();
    for (int i = 0; i < 64; i++) line_q.push_back(rand_hex());
    line_q.push_back(8'h0A);
    run_line();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
